// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional macro FETCH_PERF_CNT_EN enables the fetch counter port.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'b00,
      HALT_PEND = 2'b01,
      HALTED    = 2'b10
   } fetch_state_t;

   localparam logic [3:0]  OPC_HLT      = 4'b1111;
   localparam logic [15:0] RESET_PC     = 16'h0000;
   localparam logic [15:0] PC_INC       = 16'd2;
   localparam logic [15:0] RESET_NXT_PC = RESET_PC + PC_INC;
   localparam logic [15:0] CNT_MAX      = 16'hFFFF;

   // Sequential PC, wrapping modulo 2^16.
   function automatic logic [15:0] pc_next(input logic [15:0] a);
      return a + PC_INC;
   endfunction

   // Instructions are halfword aligned; drop bit 0.
   function automatic logic [15:0] pc_align(input logic [15:0] a);
      return a & 16'hFFFE;
   endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register with load, flush and hold.
// Flush only clears the valid bit; payload is kept.
module if_id_reg
   import fetch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_flush,
   input  logic [15:0] i_instr,
   input  logic [15:0] i_pc,
   input  logic [15:0] i_nxt_pc,
   output logic [15:0] o_instr,
   output logic [15:0] o_pc,
   output logic [15:0] o_nxt_pc,
   output logic        o_valid
);

   logic [15:0] r_instr;
   logic [15:0] r_pc;
   logic [15:0] r_nxt_pc;
   logic        r_valid;

   // Load a new fetch, invalidate on flush, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr  <= 16'h0000;
         r_pc     <= RESET_PC;
         r_nxt_pc <= RESET_NXT_PC;
         r_valid  <= 1'b0;
      end else if (i_flush) begin
         r_valid  <= 1'b0;
      end else if (i_load) begin
         r_instr  <= i_instr;
         r_pc     <= i_pc;
         r_nxt_pc <= i_nxt_pc;
         r_valid  <= 1'b1;
      end
   end

   assign o_instr  = r_instr;
   assign o_pc     = r_pc;
   assign o_nxt_pc = r_nxt_pc;
   assign o_valid  = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, halt FSM, IF/ID register.
// Define FETCH_PERF_CNT_EN to add the saturating fetch_count port.
module fetch_unit
   import fetch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [15:0] instr,
   output logic        instr_valid,
   output logic [15:0] pc,
   output logic [15:0] nxt_pc,
   output logic        halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0] fetch_count
`endif
);

   fetch_state_t r_state;
   logic [15:0]  r_fpc;
   logic         r_halted;

   logic         w_active;
   logic         w_load;
   logic         w_flush;
   logic         w_is_hlt;
   logic [15:0]  w_fpc_inc;
   logic [15:0]  w_redir_pc;

   assign w_active   = (r_state != HALTED);
   assign w_load     = (r_state == RUN) & ~redirect & ~stall;
   assign w_flush    = w_active &
                       (redirect |
                        ((r_state == HALT_PEND) & ~stall));
   assign w_is_hlt   = (imem_data[15:12] == OPC_HLT);
   assign w_fpc_inc  = pc_next(r_fpc);
   assign w_redir_pc = pc_align(redirect_pc);

   assign imem_addr  = r_fpc;
   assign halted     = r_halted;

   // Fetch PC and halt FSM; redirect beats stall, HALTED ignores both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= RUN;
         r_fpc    <= RESET_PC;
         r_halted <= 1'b0;
      end else if (w_active) begin
         if (redirect) begin
            r_fpc   <= w_redir_pc;
            r_state <= RUN;
         end else if (!stall) begin
            unique case (r_state)
               RUN: begin
                  if (w_is_hlt) begin
                     r_state <= HALT_PEND;
                  end else begin
                     r_fpc <= w_fpc_inc;
                  end
               end
               HALT_PEND: begin
                  r_state  <= HALTED;
                  r_halted <= 1'b1;
               end
               default: begin
                  r_state <= r_state;
               end
            endcase
         end
      end
   end

   if_id_reg u_if_id (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load),
      .i_flush  (w_flush),
      .i_instr  (imem_data),
      .i_pc     (r_fpc),
      .i_nxt_pc (w_fpc_inc),
      .o_instr  (instr),
      .o_pc     (pc),
      .o_nxt_pc (nxt_pc),
      .o_valid  (instr_valid)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] r_fetch_count;

   // Count valid loads into IF/ID, sticking at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_count <= 16'h0000;
      end else if (w_load && (r_fetch_count != CNT_MAX)) begin
         r_fetch_count <= r_fetch_count + 16'd1;
      end
   end

   assign fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus
// randomized stall/redirect/reset against a behavioural model.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [15:0] instr;
   logic        instr_valid;
   logic [15:0] pc;
   logic [15:0] nxt_pc;
   logic        halted;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_count;
`endif

   fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .nxt_pc      (nxt_pc),
      .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count (fetch_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // instruction memory, halfword indexed
   logic [15:0] mem [0:32767];
   assign imem_data = mem[imem_addr[15:1]];

   typedef struct {
      logic [15:0] addr;
      logic [15:0] instr;
      logic [15:0] pc;
      logic [15:0] nxt;
      logic        valid;
      logic        halted;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;

   int n_cmp = 0;
   int n_mis = 0;

   // reference model: architectural view of the fetch stage
   logic [15:0] m_fpc;
   logic [15:0] m_instr;
   logic [15:0] m_pc;
   logic [15:0] m_nxt;
   logic        m_valid;
   bit          m_pend;
   bit          m_halted;
   int          m_cnt;

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h @%0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_fpc    = 16'h0000;
      m_instr  = 16'h0000;
      m_pc     = 16'h0000;
      m_nxt    = 16'h0002;
      m_valid  = 1'b0;
      m_pend   = 0;
      m_halted = 0;
      m_cnt    = 0;
   endtask

   task automatic model_step(input logic s, input logic r,
                             input logic [15:0] rp);
      logic [15:0] w;
      if (m_halted) begin
         // frozen until reset
      end else if (r) begin
         m_fpc   = {rp[15:1], 1'b0};
         m_valid = 1'b0;
         m_pend  = 0;
      end else if (s) begin
         // hold
      end else if (m_pend) begin
         m_valid  = 1'b0;
         m_pend   = 0;
         m_halted = 1;
      end else begin
         w       = mem[m_fpc[15:1]];
         m_instr = w;
         m_pc    = m_fpc;
         m_nxt   = 16'(m_fpc + 16'd2);
         m_valid = 1'b1;
         if (m_cnt < 65535) m_cnt++;
         if (w[15:12] == 4'hF) m_pend = 1;
         else m_fpc = 16'(m_fpc + 16'd2);
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.addr   = m_fpc;
      e.instr  = m_instr;
      e.pc     = m_pc;
      e.nxt    = m_nxt;
      e.valid  = m_valid;
      e.halted = m_halted;
      e.cnt    = 16'(m_cnt);
      q.push_back(e);
   endtask

   task automatic cyc(input logic s, input logic r,
                      input logic [15:0] rp);
      @(negedge clk);
      rst_n       = 1'b1;
      stall       = s;
      redirect    = r;
      redirect_pc = rp;
      model_step(s, r, rp);
      push_exp();
   endtask

   // assert reset away from the edge and check outputs at once
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_addr", imem_addr, 16'h0000);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_pc", pc, 16'h0000);
      chk("rst_nxt", nxt_pc, 16'h0002);
      chk("rst_valid", {15'd0, instr_valid}, 16'd0);
      chk("rst_halted", {15'd0, halted}, 16'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_cnt", fetch_count, 16'h0000);
`endif
      model_reset();
      push_exp();
   endtask

   // monitor: compare DUT to the oldest expectation after each edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("imem_addr", imem_addr, mon_e.addr);
            chk("instr_valid", {15'd0, instr_valid},
                {15'd0, mon_e.valid});
            chk("halted", {15'd0, halted}, {15'd0, mon_e.halted});
            chk("pc", pc, mon_e.pc);
            chk("nxt_pc", nxt_pc, mon_e.nxt);
            if (mon_e.valid) chk("instr", instr, mon_e.instr);
`ifdef FETCH_PERF_CNT_EN
            chk("fetch_count", fetch_count, mon_e.cnt);
`endif
         end
      end
   end

   initial begin
      logic [15:0] w;
      rst_n       = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      for (int i = 0; i < 32768; i++) begin
         w = 16'($urandom);
         if (w[15:12] == 4'hF && $urandom_range(0, 3) != 0)
            w[15:12] = 4'h1;
         mem[i] = w;
      end
      for (int i = 0; i < 8; i++) mem[i] = 16'h1000 | 16'(i);
      for (int i = 32; i < 40; i++) mem[i] = 16'h2000 | 16'(i);
      mem[8]     = 16'hF000;
      mem[32767] = 16'h1234;
      model_reset();

      // sequential fetch from reset
      do_reset();
      repeat (3) cyc(1'b0, 1'b0, 16'h0000);
      // stall with pc=0x0004 for three cycles, then resume
      repeat (3) cyc(1'b1, 1'b0, 16'h0000);
      cyc(1'b0, 1'b0, 16'h0000);
      // redirect during stall to an odd address
      cyc(1'b1, 1'b1, 16'h0041);
      cyc(1'b0, 1'b0, 16'h0000);
      cyc(1'b0, 1'b0, 16'h0000);
      // halt at 0x0010, stalled once in HALT_PEND
      cyc(1'b0, 1'b1, 16'h0010);
      cyc(1'b0, 1'b0, 16'h0000);
      cyc(1'b1, 1'b0, 16'h0000);
      cyc(1'b0, 1'b0, 16'h0000);
      cyc(1'b0, 1'b1, 16'h0100);
      cyc(1'b1, 1'b1, 16'h0200);
      cyc(1'b0, 1'b0, 16'h0000);
      // address wrap
      do_reset();
      cyc(1'b0, 1'b1, 16'hFFFE);
      cyc(1'b0, 1'b0, 16'h0000);
      cyc(1'b0, 1'b0, 16'h0000);
      // reset while in HALT_PEND
      cyc(1'b0, 1'b1, 16'h0010);
      cyc(1'b0, 1'b0, 16'h0000);
      cyc(1'b1, 1'b0, 16'h0000);
      do_reset();
      cyc(1'b0, 1'b0, 16'h0000);
      cyc(1'b0, 1'b0, 16'h0000);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) < 2) begin
            do_reset();
         end else begin
            cyc(1'($urandom_range(0, 9) < 3),
                1'($urandom_range(0, 9) == 0),
                16'($urandom));
         end
      end

      // park on stall (holds in every state) and drain
      @(negedge clk);
      stall    = 1'b1;
      redirect = 1'b0;
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #2;
      n_cmp++;
      if (q.size() != 0) begin
         n_mis++;
         $display("FAIL drain: %0d entries left, expected 0",
                  q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_mis);
      $finish;
   end

   // hard time limit
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port imem_addr  out  16  instruction memory byte address (combinational from fetch PC).
REQ-004 SHALL have port imem_data  in  16  instruction word at imem_addr, valid same cycle.
REQ-005 SHALL have port stall  in  1  decode cannot accept a new instruction; hold.
REQ-006 SHALL have port redirect  in  1  taken branch/BR resolved in decode; refetch.
REQ-007 SHALL have port redirect_pc  in  16  redirect target.
REQ-008 SHALL have port instr  out  16  IF/ID instruction register.
REQ-009 SHALL have port instr_valid  out  1  instr is a live instruction.
REQ-010 SHALL have port pc  out  16  address of instr.
REQ-011 SHALL have port nxt_pc  out  16  pc + 2, registered alongside instr.
REQ-012 SHALL have port halted  out  1  HLT has left IF/ID; fetch permanently stopped.

Function
REQ-013 SHALL implement states RUN, HALT_PEND, HALTED; encodings from the shared package.
REQ-014 SHALL drive imem_addr from the fetch PC register fpc at all times.
REQ-015 RUN, redirect=0, stall=0: SHALL load IF/ID with {imem_data, fpc, fpc+2}, set instr_valid=1, fpc <= fpc+2.
REQ-016 SHALL compute fpc+2 modulo 2^16 (0xFFFE advances to 0x0000).
REQ-017 stall=1, redirect=0: SHALL hold fpc, instr, pc, nxt_pc, instr_valid and state unchanged.
REQ-018 redirect=1 (priority over stall, any state except HALTED): SHALL set fpc <= {redirect_pc[15:1],1'b0}, instr_valid <= 0, state <= RUN.
REQ-019 RUN fetching imem_data[15:12]=4'b1111 with stall=0, redirect=0: SHALL load it per REQ-015 except fpc holds; state <= HALT_PEND.
REQ-020 HALT_PEND, stall=0, redirect=0: SHALL set instr_valid <= 0, state <= HALTED; no further fetch.
REQ-021 HALT_PEND, stall=1: SHALL hold per REQ-017.
REQ-022 HALTED: SHALL ignore stall and redirect, hold fpc, keep instr_valid=0, halted=1 until reset.
REQ-023 halted SHALL be 1 exactly when state is HALTED (registered, no combinational path from inputs).
REQ-024 Latency: instruction at fpc SHALL appear on instr one clock after it is fetched.

Reset
REQ-025 rst_n=0 SHALL asynchronously set fpc=0x0000, instr=0x0000, pc=0x0000, nxt_pc=0x0002, instr_valid=0, state=RUN, halted=0.
REQ-026 Reset asserted mid-stall, mid-redirect or in HALTED SHALL override all inputs; first fetch after release is address 0x0000.

Configuration
REQ-027 Macro FETCH_PERF_CNT_EN defined: SHALL add port fetch_count  out  16, counting instructions loaded into IF/ID with instr_valid=1 (REQ-015/019 events), reset to 0, saturating at 0xFFFF.
REQ-028 Macro undefined: port fetch_count and the counter SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package SHALL hold the fetch state enum, OPC_HLT=4'b1111, RESET_PC=16'h0000, PC_INC=16'd2.
REQ-030 IF/ID register (instr, pc, nxt_pc, instr_valid with load/flush/hold) SHALL be a sub-module if_id_reg; fetch_unit holds fpc, state machine and optional counter.

Verification
REQ-031 Reset release, imem returns ADD words, stall=0 -> imem_addr 0x0000,0x0002,0x0004; instr_valid=1 from cycle 1; nxt_pc = pc+2.
REQ-032 stall=1 for 3 cycles at pc=0x0004 -> imem_addr, instr, pc frozen 3 cycles; resumes at 0x0006 next.
REQ-033 redirect=1, redirect_pc=0x0041 while stall=1 -> next cycle imem_addr=0x0040, instr_valid=0; following cycle pc=0x0040, instr_valid=1.
REQ-034 HLT at 0x0010 -> HALT_PEND with pc=0x0010; next unstalled cycle halted=1, instr_valid=0; later redirect ignored, imem_addr stays 0x0010.
REQ-035 fpc=0xFFFE, no stall -> next imem_addr=0x0000, nxt_pc=0x0000; rst_n pulsed mid-HALT_PEND -> all outputs at REQ-025 values immediately.
REQ-036 With FETCH_PERF_CNT_EN: 5 fetches, 2 stalled cycles, 1 redirect -> fetch_count=5.
